vga_rx_timing: RTL and testbench
================================

// Module: vga_rx_timing
// PURPOSE
// Sink-side VGA/HDMI-parallel timing recovery. Takes a raw hsync/vsync/DE/RGB565 stream and recovers
// per-pixel coordinates, measures total/active geometry per frame, and flags lock or loss of lock.
// It sits behind the video input, or in loopback behind the 640x480 timing generator, and feeds
// capture and frame-buffer write logic.
// PARAMETERS
// PIX_W        16  pixel data width (RGB565)
// CNT_W        11  width of the h_total/v_total measurement counters; they saturate at 2^CNT_W-1
// LOCK_FRAMES  3   consecutive matching frames needed to assert locked (range 1..15)
// PORTS
// vga_clk     in   1      pixel clock; all logic on its rising edge
// rst_n       in   1      asynchronous active-low reset
// hsync       in   1      line sync, active high
// vsync       in   1      frame sync, active high
// rgb_valid   in   1      data enable; vga_rgb is valid while high
// vga_rgb     in   PIX_W  input pixel
// pix_data    out  PIX_W  pixel aligned to pix_x/pix_y; 0 when pix_valid=0
// pix_valid   out  1      aligned data enable
// pix_x       out  10     active column; 10'h3FF when pix_valid=0
// pix_y       out  10     active row; 10'h3FF when pix_valid=0
// frame_start out  1      1-cycle pulse per detected vsync rising edge
// h_total     out  CNT_W  clocks per line, from the last complete frame
// v_total     out  CNT_W  lines per frame, from the last complete frame
// act_w       out  10     DE-high clocks per active line, from the last complete frame
// act_h       out  10     lines containing DE, from the last complete frame
// locked      out  1      geometry is stable
// timing_err  out  1      1-cycle pulse when lock is lost
// BEHAVIOUR
// - Reset: every output and internal register is 0, except pix_x/pix_y = 10'h3FF. No frame is stored.
//   The state machine is in UNLOCK.
// - Stage 1: hsync, vsync, rgb_valid and vga_rgb are registered (hs_d/vs_d/de_d/rgb_d).
//   Edges are detected by comparing each input with its registered copy: hs_rise, vs_rise, de_fall.
// - Stage 2: all outputs are registered. Input-to-pix_* latency is exactly 2 clocks.
//   frame_start, h_total, v_total, act_w, act_h, locked and timing_err update 2 clocks after the input vsync rise.
// - h_cnt: cleared to 0 on hs_rise, otherwise +1, saturating. On hs_rise the line length is h_cnt+1.
// - The first line length of a frame is recorded. Any later line whose length differs from it, or any
//   saturation of h_cnt or v_cnt, marks the frame bad.
// - v_cnt: counts hs_rise events after the frame-opening vs_rise, up to and including the closing one.
// - x counter: +1 per DE-high clock, cleared on de_fall and on hs_rise. pix_x = x value of that pixel,
//   so the first DE pixel of a line gives pix_x = 0.
// - y counter: +1 on de_fall, cleared on vs_rise. pix_y = 0 on the first active line after vsync.
//   Both x and y saturate at 10'h3FE.
// - Simultaneous hs_rise and vs_rise (the normal case): the line closes, that line counts toward the
//   closing frame, and then the new frame opens.
// - On vs_rise:
//   - The first vs_rise after reset only opens a frame; nothing is compared or published.
//   - Each later vs_rise closes a frame and publishes h_total/v_total/act_w/act_h.
//   - If a previous complete frame exists, the new geometry is compared against it.
// - State machine, evaluated on each frame close:
//   UNLOCK -> TRACK: on the first complete frame; match_cnt=0.
//   TRACK:  match (all four equal, frame not bad) -> match_cnt+1; on reaching LOCK_FRAMES -> LOCKED.
//           Mismatch or bad frame -> match_cnt=0 and stay in TRACK.
//   LOCKED: match -> stay. Mismatch or bad -> TRACK, match_cnt=0, locked=0, 1-cycle timing_err.
// - locked = 1 only in LOCKED. Coordinates and pix_valid are produced regardless of lock state.
// - Reset mid-frame: immediate return to reset state. The partial frame is discarded.
// TESTING
// 1. Drive 800x525 timing (hsync 96 clk, vsync 2 lines, DE at h 144..783 / v 35..514) with
//    vga_rgb={pix_x,pix_y} -> pix_x 0..639 and pix_y 0..479, pix_data matches with 2-clk latency,
//    h_total=800, v_total=525, act_w=640, act_h=480.
// 2. Same stream from reset, LOCK_FRAMES=3 -> locked rises 2 clk after the 5th vsync rise, not earlier.
// 3. Once locked, make one line 801 clocks -> at that frame's close locked=0 and timing_err pulses once;
//    relock after 3 more clean frames.
// 4. Drop hsync entirely for a frame -> h_cnt saturates at 2047, the frame is bad, and no lock.
// 5. Assert rst_n low mid-line at h=400 -> outputs return to reset values immediately;
//    the first post-reset vsync publishes nothing.
// 6. Change DE to 320x240 at h 224..543 -> act_w=320, act_h=240, TRACK, then relock after 3 frames.

Source files
------------

// File: rtl/vga_rx_timing.sv
// Sink-side video timing recovery: aligns pixels to recovered x/y coordinates, measures
// per-frame geometry and tracks lock against the previous complete frame.
module vga_rx_timing #(
  parameter int unsigned PIX_W       = 16,
  parameter int unsigned CNT_W       = 11,
  parameter int unsigned LOCK_FRAMES = 3
) (
  input  logic             vga_clk,
  input  logic             rst_n,
  input  logic             hsync,
  input  logic             vsync,
  input  logic             rgb_valid,
  input  logic [PIX_W-1:0] vga_rgb,
  output logic [PIX_W-1:0] pix_data,
  output logic             pix_valid,
  output logic [9:0]       pix_x,
  output logic [9:0]       pix_y,
  output logic             frame_start,
  output logic [CNT_W-1:0] h_total,
  output logic [CNT_W-1:0] v_total,
  output logic [9:0]       act_w,
  output logic [9:0]       act_h,
  output logic             locked,
  output logic             timing_err
);

  localparam logic [CNT_W-1:0] CntMax   = '1;
  localparam logic [CNT_W-1:0] CntOne   = 1;
  localparam logic [9:0]       CoordMax = 10'h3FE;
  localparam logic [3:0]       LockCnt  = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {StUnlock, StTrack, StLocked} state_e;

  // Stage 1 registers
  logic             hs_d, vs_d, de_d;
  logic [PIX_W-1:0] rgb_d;
  logic [CNT_W-1:0] h_cnt_q, v_cnt_q, first_len_q;
  logic             first_seen_q, bad_q, frame_open_q;
  logic [9:0]       x_q, y_q, aw_q;
  logic             cl_pend_q, fs_pend_q, cl_bad_q;
  logic [CNT_W-1:0] cl_h_q, cl_v_q;
  logic [9:0]       cl_aw_q, cl_ah_q;

  // Stage 2 state
  state_e           state_q;
  logic [3:0]       match_cnt_q;

  logic             hs_rise, vs_rise, de_fall;
  logic             h_sat, line_bad, v_sat_evt, close_bad, match;
  logic [CNT_W-1:0] line_len, v_next, close_h, close_v;
  logic [9:0]       x_inc, y_inc, aw_next, ah_next;

  always_comb begin
    hs_rise   = hsync & ~hs_d;
    vs_rise   = vsync & ~vs_d;
    de_fall   = ~rgb_valid & de_d;
    h_sat     = (h_cnt_q == CntMax);
    line_len  = h_sat ? CntMax : h_cnt_q + CntOne;
    line_bad  = first_seen_q && (line_len != first_len_q);
    v_next    = (v_cnt_q == CntMax) ? CntMax : v_cnt_q + CntOne;
    v_sat_evt = hs_rise && (v_cnt_q == CntMax);
    // A line closing together with vsync still belongs to the closing frame.
    close_v   = hs_rise ? v_next : v_cnt_q;
    close_h   = first_seen_q ? first_len_q : (hs_rise ? line_len : '0);
    close_bad = bad_q | h_sat | v_sat_evt | (hs_rise & line_bad);
    x_inc     = (x_q == CoordMax) ? x_q : x_q + 10'd1;
    y_inc     = (y_q == CoordMax) ? y_q : y_q + 10'd1;
    aw_next   = de_fall ? x_q + 10'd1 : aw_q;
    ah_next   = de_fall ? y_inc : y_q;
    match     = !cl_bad_q && (cl_h_q == h_total) && (cl_v_q == v_total) &&
                (cl_aw_q == act_w) && (cl_ah_q == act_h);
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_d         <= 1'b0;
      vs_d         <= 1'b0;
      de_d         <= 1'b0;
      rgb_d        <= '0;
      h_cnt_q      <= '0;
      v_cnt_q      <= '0;
      first_len_q  <= '0;
      first_seen_q <= 1'b0;
      bad_q        <= 1'b0;
      frame_open_q <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      aw_q         <= '0;
      cl_pend_q    <= 1'b0;
      fs_pend_q    <= 1'b0;
      cl_bad_q     <= 1'b0;
      cl_h_q       <= '0;
      cl_v_q       <= '0;
      cl_aw_q      <= '0;
      cl_ah_q      <= '0;
    end else begin
      hs_d    <= hsync;
      vs_d    <= vsync;
      de_d    <= rgb_valid;
      rgb_d   <= vga_rgb;
      h_cnt_q <= hs_rise ? '0 : (h_sat ? h_cnt_q : h_cnt_q + CntOne);
      // x_q is the column of the pixel currently held in rgb_d.
      if (de_fall || hs_rise) begin
        x_q <= '0;
      end else if (rgb_valid && de_d) begin
        x_q <= x_inc;
      end
      if (vs_rise) begin
        y_q <= '0;
      end else if (de_fall) begin
        y_q <= y_inc;
      end
      if (vs_rise) begin
        frame_open_q <= 1'b1;
        first_seen_q <= 1'b0;
        first_len_q  <= '0;
        bad_q        <= 1'b0;
        v_cnt_q      <= '0;
        aw_q         <= '0;
        cl_h_q       <= close_h;
        cl_v_q       <= close_v;
        cl_aw_q      <= aw_next;
        cl_ah_q      <= ah_next;
        cl_bad_q     <= close_bad;
      end else begin
        if (hs_rise) begin
          v_cnt_q <= v_next;
          if (!first_seen_q) begin
            first_seen_q <= 1'b1;
            first_len_q  <= line_len;
          end
        end
        if (close_bad) begin
          bad_q <= 1'b1;
        end
        if (de_fall) begin
          aw_q <= aw_next;
        end
      end
      cl_pend_q <= vs_rise & frame_open_q;
      fs_pend_q <= vs_rise;
    end
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_data    <= '0;
      pix_valid   <= 1'b0;
      pix_x       <= 10'h3FF;
      pix_y       <= 10'h3FF;
      frame_start <= 1'b0;
      h_total     <= '0;
      v_total     <= '0;
      act_w       <= '0;
      act_h       <= '0;
      locked      <= 1'b0;
      timing_err  <= 1'b0;
      state_q     <= StUnlock;
      match_cnt_q <= '0;
    end else begin
      pix_valid   <= de_d;
      pix_data    <= de_d ? rgb_d : '0;
      pix_x       <= de_d ? x_q : 10'h3FF;
      pix_y       <= de_d ? y_q : 10'h3FF;
      frame_start <= fs_pend_q;
      timing_err  <= 1'b0;
      if (cl_pend_q) begin
        h_total <= cl_h_q;
        v_total <= cl_v_q;
        act_w   <= cl_aw_q;
        act_h   <= cl_ah_q;
        case (state_q)
          StUnlock: begin
            state_q     <= StTrack;
            match_cnt_q <= '0;
          end
          StTrack: begin
            if (match) begin
              if (match_cnt_q + 4'd1 >= LockCnt) begin
                state_q     <= StLocked;
                locked      <= 1'b1;
                match_cnt_q <= '0;
              end else begin
                match_cnt_q <= match_cnt_q + 4'd1;
              end
            end else begin
              match_cnt_q <= '0;
            end
          end
          StLocked: begin
            if (!match) begin
              state_q     <= StTrack;
              locked      <= 1'b0;
              timing_err  <= 1'b1;
              match_cnt_q <= '0;
            end
          end
          default: begin
            state_q     <= StUnlock;
            locked      <= 1'b0;
            match_cnt_q <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vga_rx_timing.sv
// Directed bench for vga_rx_timing on a compact 90x24 raster (DE 50x16, alternate 25x8).
module tb_vga_rx_timing;

  localparam int H_TOT = 90;
  localparam int V_TOT = 24;

  logic        vga_clk = 1'b0;
  logic        rst_n;
  logic        hsync, vsync, rgb_valid;
  logic [15:0] vga_rgb;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic [9:0]  pix_x, pix_y;
  logic        frame_start;
  logic [10:0] h_total, v_total;
  logic [9:0]  act_w, act_h;
  logic        locked, timing_err;

  vga_rx_timing #(
    .PIX_W(16),
    .CNT_W(11),
    .LOCK_FRAMES(3)
  ) dut (
    .vga_clk    (vga_clk),
    .rst_n      (rst_n),
    .hsync      (hsync),
    .vsync      (vsync),
    .rgb_valid  (rgb_valid),
    .vga_rgb    (vga_rgb),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .frame_start(frame_start),
    .h_total    (h_total),
    .v_total    (v_total),
    .act_w      (act_w),
    .act_h      (act_h),
    .locked     (locked),
    .timing_err (timing_err)
  );

  always #5 vga_clk = ~vga_clk;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          te_cnt, fs_cnt;
  logic [36:0] exp_prev, exp_cur;
  logic        lk_pre, fs_pre, s_fs, s_lk;
  logic [10:0] s_ht, s_vt;
  logic [9:0]  s_aw, s_ah;

  localparam logic [36:0] PixIdle = {1'b0, 10'h3FF, 10'h3FF, 16'h0000};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives one frame; the snapshot at h=1 of line 0 shows the close of the previous frame.
  task automatic run_frame(input int dh0, input int dw, input int dv0, input int dhh,
                           input int bad_v, input bit drop_hs, input int stop_v, input bit chk);
    logic       de;
    logic [9:0] ex, ey;
    logic [15:0] rgb;
    te_cnt = 0;
    fs_cnt = 0;
    for (int v = 0; v < V_TOT; v++) begin
      for (int h = 0; h < ((v == bad_v) ? H_TOT + 1 : H_TOT); h++) begin
        if (v == stop_v && h == 45) return;
        de  = (h >= dh0) && (h < dh0 + dw) && (v >= dv0) && (v < dv0 + dhh);
        ex  = 10'(h - dh0);
        ey  = 10'(v - dv0);
        rgb = {ex[7:0], ey[7:0]};
        hsync     = (h < 8) && (!drop_hs || v == 0);
        vsync     = (v < 2);
        rgb_valid = de;
        vga_rgb   = de ? rgb : 16'hDEAD;
        exp_cur   = de ? {1'b1, ex, ey, rgb} : PixIdle;
        @(posedge vga_clk);
        #1;
        if (chk) check("pix", 64'({pix_valid, pix_x, pix_y, pix_data}), 64'(exp_prev));
        exp_prev = exp_cur;
        te_cnt += int'(timing_err);
        fs_cnt += int'(frame_start);
        if (v == 0 && h == 0) begin
          lk_pre = locked;
          fs_pre = frame_start;
        end
        if (v == 0 && h == 1) begin
          s_fs = frame_start;
          s_lk = locked;
          s_ht = h_total;
          s_vt = v_total;
          s_aw = act_w;
          s_ah = act_h;
        end
      end
    end
  endtask

  task automatic check_close(input string tag, input int ht, input int vt, input int aw,
                             input int ah, input bit lk, input int te);
    check({tag, "_ht"}, 64'(s_ht), 64'(ht));
    check({tag, "_vt"}, 64'(s_vt), 64'(vt));
    check({tag, "_aw"}, 64'(s_aw), 64'(aw));
    check({tag, "_ah"}, 64'(s_ah), 64'(ah));
    check({tag, "_lk"}, 64'(s_lk), 64'(lk));
    check({tag, "_te"}, 64'(te_cnt), 64'(te));
  endtask

  initial begin
    rst_n = 1'b0;
    hsync = 1'b0;
    vsync = 1'b0;
    rgb_valid = 1'b0;
    vga_rgb = 16'h0;
    exp_prev = PixIdle;
    repeat (3) @(posedge vga_clk);
    #1;
    check("rst_pix_x", 64'(pix_x), 64'h3FF);
    check("rst_pix_y", 64'(pix_y), 64'h3FF);
    check("rst_pix_valid", 64'(pix_valid), 64'h0);
    check("rst_ht", 64'(h_total), 64'h0);
    check("rst_locked", 64'(locked), 64'h0);
    rst_n = 1'b1;

    // Normal raster, pixel alignment checked every clock of the first frame
    run_frame(20, 50, 4, 16, -1, 1'b0, 99, 1'b1);
    check("f1_fs_pre", 64'(fs_pre), 64'h0);
    check("f1_fs", 64'(s_fs), 64'h1);
    check("f1_ht_unpublished", 64'(s_ht), 64'h0);
    run_frame(20, 50, 4, 16, -1, 1'b0, 99, 1'b0);
    check_close("f2", 90, 24, 50, 16, 1'b0, 0);
    run_frame(20, 50, 4, 16, -1, 1'b0, 99, 1'b0);
    check_close("f3", 90, 24, 50, 16, 1'b0, 0);
    run_frame(20, 50, 4, 16, -1, 1'b0, 99, 1'b0);
    check_close("f4", 90, 24, 50, 16, 1'b0, 0);
    run_frame(20, 50, 4, 16, -1, 1'b0, 99, 1'b0);
    check("f5_lk_pre", 64'(lk_pre), 64'h0);
    check_close("f5", 90, 24, 50, 16, 1'b1, 0);

    // One 91-clock line
    run_frame(20, 50, 4, 16, 10, 1'b0, 99, 1'b0);
    check_close("f6", 90, 24, 50, 16, 1'b1, 0);
    run_frame(20, 50, 4, 16, -1, 1'b0, 99, 1'b0);
    check_close("f7", 90, 24, 50, 16, 1'b0, 1);
    run_frame(20, 50, 4, 16, -1, 1'b0, 99, 1'b0);
    check_close("f8", 90, 24, 50, 16, 1'b0, 0);
    run_frame(20, 50, 4, 16, -1, 1'b0, 99, 1'b0);
    check_close("f9", 90, 24, 50, 16, 1'b0, 0);

    // Active window shrinks while locked
    run_frame(30, 25, 6, 8, -1, 1'b0, 99, 1'b0);
    check_close("f10", 90, 24, 50, 16, 1'b1, 0);
    check("f10_fs_cnt", 64'(fs_cnt), 64'h1);
    run_frame(30, 25, 6, 8, -1, 1'b0, 99, 1'b1);
    check_close("f11", 90, 24, 25, 8, 1'b0, 1);
    run_frame(30, 25, 6, 8, -1, 1'b0, 99, 1'b0);
    check_close("f12", 90, 24, 25, 8, 1'b0, 0);
    run_frame(30, 25, 6, 8, -1, 1'b0, 99, 1'b0);
    check_close("f13", 90, 24, 25, 8, 1'b0, 0);

    // hsync missing after the frame-opening pulse
    run_frame(30, 25, 6, 8, -1, 1'b1, 99, 1'b0);
    check("f14_lk_pre", 64'(lk_pre), 64'h0);
    check_close("f14", 90, 24, 25, 8, 1'b1, 0);
    run_frame(30, 25, 6, 8, -1, 1'b0, 99, 1'b0);
    check_close("f15", 2047, 1, 25, 8, 1'b0, 1);
    run_frame(30, 25, 6, 8, -1, 1'b0, 99, 1'b0);
    check_close("f16", 90, 24, 25, 8, 1'b0, 0);

    // Reset in the middle of an active line
    run_frame(30, 25, 6, 8, -1, 1'b0, 10, 1'b0);
    check_close("f17", 90, 24, 25, 8, 1'b0, 0);
    check("pre_rst_valid", 64'(pix_valid), 64'h1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(pix_valid), 64'h0);
    check("mid_rst_pix_x", 64'(pix_x), 64'h3FF);
    check("mid_rst_ht", 64'(h_total), 64'h0);
    check("mid_rst_aw", 64'(act_w), 64'h0);
    hsync = 1'b0;
    vsync = 1'b0;
    rgb_valid = 1'b0;
    vga_rgb = 16'h0;
    repeat (3) @(posedge vga_clk);
    #1;
    rst_n = 1'b1;
    exp_prev = PixIdle;
    run_frame(30, 25, 6, 8, -1, 1'b0, 99, 1'b1);
    check("f18_fs", 64'(s_fs), 64'h1);
    check_close("f18", 0, 0, 0, 0, 1'b0, 0);
    run_frame(30, 25, 6, 8, -1, 1'b0, 1, 1'b0);
    check_close("f19", 90, 24, 25, 8, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
